// File: rtl/receive_img.sv
// rtl/receive_img.sv - UART 8N1 image receiver writing greyscale pixels into a BRAM
//
// Purpose:
//   Receives 8N1 UART bytes on rx and writes each accepted byte to the next
//   pixel address of an image buffer. After IMG_PIXELS writes, the image is
//   complete. Further bytes are then ignored until rearm is pulsed.
//
// Optional feature (macro RECEIVE_IMG_TIMEOUT_EN):
//   When defined, a partial image is dropped (index back to 0) after
//   TIMEOUT_CYCLES idle cycles. When undefined, partial images persist.
//
// Ports:
//   clk        in   system clock
//   rst_in     in   asynchronous active-high reset
//   rx         in   asynchronous UART line, idle high, LSB first
//   rearm      in   one-cycle pulse: clear img_done, restart at pixel 0
//   wr_addr    out  BRAM write address (holds when wr_en=0)
//   wr_data    out  BRAM write data (holds when wr_en=0)
//   wr_en      out  one-cycle BRAM write strobe
//   img_done   out  sticky, full image written
//   busy       out  UART frame in progress
//   frame_err  out  one-cycle pulse on a bad stop bit
//   err_count  out  saturating framing error count

module receive_img #(
   parameter int CLOCKS_PER_BAUD = 50,
   parameter int IMG_PIXELS      = 16384,
   parameter int ADDR_WIDTH      = 14,
   parameter int TIMEOUT_CYCLES  = 100000
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  rx,
   input  logic                  rearm,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  wr_en,
   output logic                  img_done,
   output logic                  busy,
   output logic                  frame_err,
   output logic [7:0]            err_count
);

   localparam int BAUD_W = $clog2(CLOCKS_PER_BAUD);
   localparam logic [BAUD_W-1:0]     HALF_M1  = BAUD_W'(CLOCKS_PER_BAUD / 2 - 1);
   localparam logic [BAUD_W-1:0]     FULL_M1  = BAUD_W'(CLOCKS_PER_BAUD - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_PIXELS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_HIGH
   } state_t;

   state_t                r_state;
   logic                  r_rx_meta;
   logic                  r_rx_sync;
   logic [BAUD_W-1:0]     r_baud_cnt;
   logic [2:0]            r_bit_cnt;
   logic [7:0]            r_shift;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [ADDR_WIDTH-1:0] r_wr_addr;
   logic [7:0]            r_wr_data;
   logic                  r_wr_en;
   logic                  r_img_done;
   logic                  r_frame_err;
   logic [7:0]            r_err_count;
   logic                  w_timeout;

   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;
   assign wr_en     = r_wr_en;
   assign img_done  = r_img_done;
   assign frame_err = r_frame_err;
   assign err_count = r_err_count;
   assign busy      = (r_state != S_IDLE);

   // Two-flop synchronizer; resets to the idle line level so no false start bit.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
      end else begin
         r_rx_meta <= rx;
         r_rx_sync <= r_rx_meta;
      end
   end

`ifdef RECEIVE_IMG_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   logic [TO_W-1:0] r_idle_cnt;

   // Counts only while a partial image is waiting in IDLE; a start bit moves
   // the FSM out of IDLE, which clears the count.
   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_idle_cnt <= '0;
      end else if (r_state != S_IDLE || r_index == '0 || r_img_done) begin
         r_idle_cnt <= '0;
      end else if (r_idle_cnt != TO_LIMIT) begin
         r_idle_cnt <= r_idle_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_idle_cnt == TO_LIMIT);
`else
   // Timeout disabled: constant false, parameter kept only for interface parity.
   assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge clk or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_baud_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_index     <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_wr_en     <= 1'b0;
         r_img_done  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_count <= '0;
      end else begin
         r_wr_en     <= 1'b0;
         r_frame_err <= 1'b0;

         // Pixel index advances the cycle after the write strobe; rearm wins.
         if (rearm) begin
            r_index    <= '0;
            r_img_done <= 1'b0;
         end else if (w_timeout) begin
            r_index <= '0;
         end else if (r_wr_en) begin
            if (r_index == LAST_IDX) begin
               r_index    <= '0;
               r_img_done <= 1'b1;
            end else begin
               r_index <= r_index + 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (!r_rx_sync) begin
                  r_state    <= S_START;
                  r_baud_cnt <= '0;
               end
            end

            // Sample mid start bit; a high line here was only a glitch.
            S_START: begin
               if (r_baud_cnt == HALF_M1) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_state    <= r_rx_sync ? S_IDLE : S_DATA;
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_DATA: begin
               if (r_baud_cnt == FULL_M1) begin
                  r_baud_cnt <= '0;
                  r_shift    <= {r_rx_sync, r_shift[7:1]};
                  if (r_bit_cnt == 3'd7) begin
                     r_state <= S_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            S_STOP: begin
               if (r_baud_cnt == FULL_M1) begin
                  r_baud_cnt <= '0;
                  if (r_rx_sync) begin
                     r_state <= S_IDLE;
                     // A completed image or a coincident rearm swallows the byte.
                     if (!r_img_done && !rearm) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= r_shift;
                        r_wr_addr <= r_index;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                     if (r_err_count != 8'hFF) begin
                        r_err_count <= r_err_count + 1'b1;
                     end
                     r_state <= S_WAIT_HIGH;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + 1'b1;
               end
            end

            // Hold off until the line returns high so a stuck-low line is not
            // mistaken for a stream of start bits.
            S_WAIT_HIGH: begin
               if (r_rx_sync) begin
                  r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_receive_img.sv
// tb/tb_receive_img.sv - scoreboard testbench for receive_img

module tb_receive_img;

   localparam int CPB = 50;

   logic       clk = 1'b0;
   logic       rst_in;
   logic       rx;
   logic       rearm;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       img_done;
   logic       busy;
   logic       frame_err;
   logic [7:0] err_count;

   receive_img #(
      .CLOCKS_PER_BAUD(CPB),
      .IMG_PIXELS     (4),
      .ADDR_WIDTH     (2),
      .TIMEOUT_CYCLES (1000)
   ) dut (
      .clk      (clk),
      .rst_in   (rst_in),
      .rx       (rx),
      .rearm    (rearm),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .img_done (img_done),
      .busy     (busy),
      .frame_err(frame_err),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int start_cycle = 0;
   int latency = -1;
   int fe_count = 0;
   logic prev_wr_en = 1'b0;
   logic [9:0] exp_q[$];
   logic [9:0] exp_e;

   always @(posedge clk) cycle++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT strobes a write.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         check("wr_en_single_cycle", {31'd0, prev_wr_en}, 32'd0);
         if (latency < 0) latency = cycle - start_cycle;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", wr_addr, wr_data);
         end else begin
            exp_e = exp_q.pop_front();
            check("wr_addr", {30'd0, wr_addr}, {30'd0, exp_e[9:8]});
            check("wr_data", {24'd0, wr_data}, {24'd0, exp_e[7:0]});
         end
      end
      if (frame_err === 1'b1) fe_count++;
      prev_wr_en = wr_en;
   end

   task automatic expect_write(input logic [1:0] a, input logic [7:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop_bit);
      @(negedge clk);
      rx = 1'b0;
      start_cycle = cycle;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic pulse_rearm();
      @(negedge clk);
      rearm = 1'b1;
      @(negedge clk);
      rearm = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wr_en"},     {31'd0, wr_en},     32'd0);
      check({tag, "_wr_addr"},   {30'd0, wr_addr},   32'd0);
      check({tag, "_wr_data"},   {24'd0, wr_data},   32'd0);
      check({tag, "_img_done"},  {31'd0, img_done},  32'd0);
      check({tag, "_busy"},      {31'd0, busy},      32'd0);
      check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
      check({tag, "_err_count"}, {24'd0, err_count}, 32'd0);
   endtask

   initial begin
      rst_in = 1'b1;
      rx     = 1'b1;
      rearm  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_in = 1'b0;
      repeat (5) @(negedge clk);

      // Single byte: address 0, latency about 478 cycles from the start edge.
      expect_write(2'd0, 8'hA5);
      send_byte(8'hA5, 1'b1);
      check("latency_in_range", {31'd0, (latency >= 470 && latency <= 485)}, 32'd1);
      check("img_done_after_1", {31'd0, img_done}, 32'd0);

      // Restart at pixel 0, then fill a whole 4-pixel image.
      pulse_rearm();
      expect_write(2'd0, 8'h01);
      send_byte(8'h01, 1'b1);
      expect_write(2'd1, 8'h02);
      send_byte(8'h02, 1'b1);
      expect_write(2'd2, 8'h03);
      send_byte(8'h03, 1'b1);
      check("img_done_before_last", {31'd0, img_done}, 32'd0);
      expect_write(2'd3, 8'hFF);
      send_byte(8'hFF, 1'b1);
      check("img_done_after_last", {31'd0, img_done}, 32'd1);

      // Image complete: this byte must not be written.
      send_byte(8'h77, 1'b1);
      check("img_done_sticky", {31'd0, img_done}, 32'd1);

      pulse_rearm();
      check("img_done_rearm", {31'd0, img_done}, 32'd0);
      expect_write(2'd0, 8'h42);
      send_byte(8'h42, 1'b1);

      // Bad stop bit: byte dropped, error counted; next byte goes to addr 1.
      send_byte(8'h3C, 1'b0);
      check("frame_err_pulses", fe_count, 32'd1);
      check("err_count_1", {24'd0, err_count}, 32'd1);
      expect_write(2'd1, 8'h11);
      send_byte(8'h11, 1'b1);

      // Short low glitch: FSM leaves IDLE but returns without error or write.
      @(negedge clk);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_busy", {31'd0, busy}, 32'd1);
      repeat (2) @(negedge clk);
      rx = 1'b1;
      repeat (60) @(negedge clk);
      check("glitch_idle", {31'd0, busy}, 32'd0);
      check("glitch_no_frame_err", fe_count, 32'd1);

      // Reset in the middle of the data bits of a frame.
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("busy_mid_frame", {31'd0, busy}, 32'd1);
      #1 rst_in = 1'b1;
      #1 check_all_zero("midframe_reset");
      rx = 1'b1;
      repeat (5) @(negedge clk);
      rst_in = 1'b0;
      repeat (5) @(negedge clk);

      expect_write(2'd0, 8'h99);
      send_byte(8'h99, 1'b1);
      expect_write(2'd1, 8'hAB);
      send_byte(8'hAB, 1'b1);
      repeat (1100) @(negedge clk);
`ifdef RECEIVE_IMG_TIMEOUT_EN
      expect_write(2'd0, 8'hCD);
`else
      expect_write(2'd2, 8'hCD);
`endif
      send_byte(8'hCD, 1'b1);

      repeat (10) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);
      check("frame_err_total", fe_count, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
